param_register_file: RTL and testbench

// Parametrised 2-read/1-write register file; successor to the fixed 32x32 datapath register file.

---
 rtl/param_register_file.sv | 106 ++++++++++
 tb/tb_param_register_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Parametrised 2-read/1-write register file with optional zero register and write bypass.
// After reset, a clear sequencer zeroes every entry before Ready rises.
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LAST_C  = DEPTH_C - 1'b1;

  typedef enum logic {CLEAR, READY} stateT;

  stateT                 state, stateNext;
  logic [ADDR_WIDTH:0]   clrCnt, clrCntNext;
  logic                  memWe;
  logic [IDX_W-1:0]      memIdx;
  logic [DATA_WIDTH-1:0] memWd;
  logic                  writeAccept;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Out-of-range and zero-register writes are dropped and never forwarded.
  assign writeAccept = RegWrite && ({1'b0, WriteRegister} < DEPTH_C) &&
                       !((ZERO_REG != 0) && (WriteRegister == '0));

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= CLEAR;
      clrCnt <= '0;
    end else begin
      state  <= stateNext;
      clrCnt <= clrCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    memWe      = 1'b0;
    memIdx     = WriteRegister[IDX_W-1:0];
    memWd      = WriteData;
    case (state)
      CLEAR: begin
        memWe      = 1'b1;
        memIdx     = clrCnt[IDX_W-1:0];
        memWd      = '0;
        clrCntNext = clrCnt + 1'b1;
        if (clrCnt == LAST_C) stateNext = READY;
      end
      READY:   memWe = writeAccept;
      default: stateNext = CLEAR;
    endcase
  end

  // Storage has no reset; the clear sequence is what empties it.
  always_ff @(negedge Clk) begin
    if (memWe) mem[memIdx] <= memWd;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gRead
      logic [ADDR_WIDTH-1:0] addr;
      logic                  inRange;
      logic                  isZero;
      logic                  hit;
      logic [DATA_WIDTH-1:0] dataReg;

      assign addr    = (gi == 0) ? ReadRegister1 : ReadRegister2;
      assign inRange = ({1'b0, addr} < DEPTH_C);
      assign isZero  = (ZERO_REG != 0) && (addr == '0);
      assign hit     = (BYPASS != 0) && writeAccept && (WriteRegister == addr);

      always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          dataReg <= '0;
        end else if (state != READY || !inRange || isZero) begin
          dataReg <= '0;
        end else if (hit) begin
          dataReg <= WriteData;
        end else begin
          dataReg <= mem[addr[IDX_W-1:0]];
        end
      end
    end
  endgenerate

  assign ReadData1 = gRead[0].dataReg;
  assign ReadData2 = gRead[1].dataReg;
  assign Ready     = (state == READY);

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: default instance plus a DEPTH=24, no-zero-reg, no-bypass instance,
// driven together and checked against vector tables and an array-based reference model.
module tb_param_register_file;

  logic        Clk = 1'b1;
  logic        Rst_n;
  logic        rw;
  logic [4:0]  wr, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] rdA1, rdA2, rdB1, rdB2;
  logic        rdyA, rdyB;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dutA (
    .Clk(Clk), .Rst_n(Rst_n), .ReadRegister1(ra1), .ReadRegister2(ra2), .WriteRegister(wr),
    .WriteData(wd), .RegWrite(rw), .ReadData1(rdA1), .ReadData2(rdA2), .Ready(rdyA));

  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .ReadRegister1(ra1), .ReadRegister2(ra2), .WriteRegister(wr),
    .WriteData(wd), .RegWrite(rw), .ReadData1(rdB1), .ReadData2(rdB2), .Ready(rdyB));

  // Reference model: index 0 = dutA, 1 = dutB
  logic [31:0] mMem [2][32];
  int          mDepth [2] = '{32, 24};
  bit          mZero  [2] = '{1'b1, 1'b0};
  bit          mByp   [2] = '{1'b1, 1'b0};
  int          mEdges [2];
  logic [31:0] eRd1 [2], eRd2 [2];
  logic        eRdy [2];

  function automatic void modelReset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) mMem[c][i] = '0;
      mEdges[c] = 0;
      eRd1[c] = '0;
      eRd2[c] = '0;
      eRdy[c] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] modelRead(input int c, input logic [4:0] a, input bit acc);
    if (int'(a) >= mDepth[c] || (mZero[c] && a == 5'd0)) return 32'h0;
    if (mByp[c] && acc && a == wr) return wd;
    return mMem[c][a];
  endfunction

  function automatic void modelEdge(input int c);
    bit acc;
    if (mEdges[c] < mDepth[c]) begin
      mEdges[c]++;
      eRd1[c] = '0;
      eRd2[c] = '0;
    end else begin
      acc = rw && (int'(wr) < mDepth[c]) && !(mZero[c] && wr == 5'd0);
      eRd1[c] = modelRead(c, ra1, acc);
      eRd2[c] = modelRead(c, ra2, acc);
      if (acc) mMem[c][wr] = wd;
    end
    eRdy[c] = (mEdges[c] >= mDepth[c]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input string tag);
    modelEdge(0);
    modelEdge(1);
    @(negedge Clk);
    #1;
    check({tag, ".A.rd1"}, rdA1, eRd1[0]);
    check({tag, ".A.rd2"}, rdA2, eRd2[0]);
    check({tag, ".A.rdy"}, {31'b0, rdyA}, {31'b0, eRdy[0]});
    check({tag, ".B.rd1"}, rdB1, eRd1[1]);
    check({tag, ".B.rd2"}, rdB2, eRd2[1]);
    check({tag, ".B.rdy"}, {31'b0, rdyB}, {31'b0, eRdy[1]});
    $display("[TB] %s rw=%0d wr=%0d wd=%h ra=%0d/%0d A=%h/%h/%0d B=%h/%h/%0d",
             tag, rw, wr, wd, ra1, ra2, rdA1, rdA2, rdyA, rdB1, rdB2, rdyB);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".A.rd1"}, rdA1, 32'h0);
    check({tag, ".A.rd2"}, rdA2, 32'h0);
    check({tag, ".A.rdy"}, {31'b0, rdyA}, 32'h0);
    check({tag, ".B.rd1"}, rdB1, 32'h0);
    check({tag, ".B.rdy"}, {31'b0, rdyB}, 32'h0);
    $display("[TB] %s reset asserted A=%h/%h/%0d B=%h/%h/%0d", tag, rdA1, rdA2, rdyA, rdB1, rdB2, rdyB);
  endtask

  task automatic setIn(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    rw = w; wr = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wdat;
    logic [4:0]  r1, r2;
    logic [31:0] a1, a2, b1, b2;
  } vecT;

  vecT vecs [13];

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd5,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd8,  32'hFFFFFFFF, 5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0};
    vecs[3]  = '{1'b1, 5'd16, 32'hF0F0F0F0, 5'd16, 5'd16, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd16, 5'd16, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    vecs[5]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd8,  32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h12345678, 32'h12345678};
    vecs[7]  = '{1'b1, 5'd30, 32'hAAAAAAAA, 5'd30, 5'd30, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd30, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 5'd23, 32'h55555555, 5'd23, 5'd30, 32'h55555555, 32'hAAAAAAAA, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd23, 5'd0,  32'h55555555, 32'h0,        32'h55555555, 32'h12345678};
    vecs[11] = '{1'b1, 5'd31, 32'h77777777, 5'd31, 5'd23, 32'h77777777, 32'h55555555, 32'h0,        32'h55555555};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd16, 32'h77777777, 32'hF0F0F0F0, 32'h0,        32'hF0F0F0F0};

    Rst_n = 1'b0;
    setIn(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    modelReset();
    #2;
    checkResetOutputs("por");
    @(negedge Clk); #1;
    @(negedge Clk); #1;
    Rst_n = 1'b1;

    // Clear phase with a write to r9 that must be ignored by the clearing instance.
    for (int i = 1; i <= 32; i++) begin
      if (i <= 24) setIn(1'b1, 5'd9, 32'h0F0F0F0F, 5'd9, 5'd31);
      else         setIn(1'b0, 5'd9, 32'h0F0F0F0F, 5'd9, 5'd31);
      cycle($sformatf("clear%0d", i));
      check("clr.A.readyEdge", {31'b0, rdyA}, (i >= 32) ? 32'h1 : 32'h0);
      check("clr.B.readyEdge", {31'b0, rdyB}, (i >= 24) ? 32'h1 : 32'h0);
    end

    for (int v = 0; v < 13; v++) begin
      setIn(vecs[v].w, vecs[v].wa, vecs[v].wdat, vecs[v].r1, vecs[v].r2);
      cycle($sformatf("vec%0d", v));
      check($sformatf("vec%0d.A1", v), rdA1, vecs[v].a1);
      check($sformatf("vec%0d.A2", v), rdA2, vecs[v].a2);
      check($sformatf("vec%0d.B1", v), rdB1, vecs[v].b1);
      check($sformatf("vec%0d.B2", v), rdB2, vecs[v].b2);
    end

    // Reset while READY with non-zero read data: outputs must drop without a clock edge.
    setIn(1'b0, 5'd0, 32'h0, 5'd8, 5'd16);
    cycle("preRst");
    check("preRst.A1", rdA1, 32'hFFFFFFFF);
    Rst_n = 1'b0;
    modelReset();
    #1;
    checkResetOutputs("rstReady");
    @(negedge Clk); #1;
    Rst_n = 1'b1;

    setIn(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8);
    for (int i = 1; i <= 10; i++) cycle($sformatf("partClear%0d", i));
    Rst_n = 1'b0;
    modelReset();
    #1;
    checkResetOutputs("rstClear");
    @(negedge Clk); #1;
    Rst_n = 1'b1;

    setIn(1'b0, 5'd0, 32'h0, 5'd8, 5'd16);
    for (int i = 1; i <= 32; i++) begin
      cycle($sformatf("reclear%0d", i));
      check("reclr.A.readyEdge", {31'b0, rdyA}, (i >= 32) ? 32'h1 : 32'h0);
    end
    cycle("lost");
    check("lost.A1", rdA1, 32'h0);
    check("lost.A2", rdA2, 32'h0);
    check("lost.B1", rdB1, 32'h0);

    // Randomised traffic, reads biased towards the write address to exercise forwarding.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      setIn(1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
      cycle($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
